// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU arbiter and its environment.
//   - ALU opcode values carried on the 4-bit alucont buses
//   - arbiter FSM state type
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// A request is accepted in IDLE, executed for one cycle (EXEC), and its result
// is held in RESP until the granted requester takes it. Ties go to the port
// named by a round-robin pointer that flips to the other port after each
// completed response.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   reqN_valid/ready/alucont/a/b  request handshake and operands, N = 0,1
//   rspN_valid/ready/res/zero     response handshake and result, N = 0,1
//   alu_alucont/rd1/rd2           operands driven to the external ALU
//   alu_res/alu_zero              result returned by the external ALU
//   grant0_cnt/grant1_cnt         accept counters (only with ALU_ARB_CNT_EN)
//
// Build option: define ALU_ARB_CNT_EN to add the 16-bit per-port accept
// counters and their output ports.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_alucont,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_alucont,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_res,
   output logic             rsp0_zero,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_res,
   output logic             rsp1_zero,
   output logic [3:0]       alu_alucont,
   output logic [WIDTH-1:0] alu_rd1,
   output logic [WIDTH-1:0] alu_rd2,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             alu_zero
`ifdef ALU_ARB_CNT_EN
   ,
   output logic [15:0]      grant0_cnt,
   output logic [15:0]      grant1_cnt
`endif
);

   state_t           state, state_nxt;
   logic             rr;        // port that wins a tie
   logic             grant;     // port owning the in-flight operation
   logic             sel;       // port selected in IDLE
   logic             accept;
   logic             rsp_fire;
   logic [3:0]       op_alucont;
   logic [WIDTH-1:0] op_a, op_b;
   logic [WIDTH-1:0] res_q;
   logic             zero_q;

   always_comb begin
      // Lone requester wins; on a tie the round-robin pointer decides.
      sel        = (req0_valid && req1_valid) ? rr : req1_valid;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      accept     = 1'b0;
      rsp_fire   = 1'b0;
      state_nxt  = state;
      unique case (state)
         IDLE: begin
            // Ready is gated by reset so nothing looks accepted while held.
            if ((req0_valid || req1_valid) && !reset) begin
               req0_ready = !sel;
               req1_ready = sel;
               accept     = 1'b1;
               state_nxt  = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp0_valid = !grant;
            rsp1_valid = grant;
            rsp_fire   = grant ? rsp1_ready : rsp0_ready;
            if (rsp_fire) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr         <= 1'b0;
         grant      <= 1'b0;
         op_alucont <= '0;
         op_a       <= '0;
         op_b       <= '0;
         res_q      <= '0;
         zero_q     <= 1'b0;
      end else begin
         if (accept) begin
            grant      <= sel;
            op_alucont <= sel ? req1_alucont : req0_alucont;
            op_a       <= sel ? req1_a : req0_a;
            op_b       <= sel ? req1_b : req0_b;
         end
         if (state == EXEC) begin
            res_q  <= alu_res;
            zero_q <= alu_zero;
         end
         if (rsp_fire) rr <= !grant;
      end
   end

`ifdef ALU_ARB_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant0_cnt <= '0;
         grant1_cnt <= '0;
      end else if (accept) begin
         if (sel) grant1_cnt <= grant1_cnt + 16'd1;
         else     grant0_cnt <= grant0_cnt + 16'd1;
      end
   end
`endif

   // The ALU only ever sees registered operands, never the request ports.
   assign alu_alucont = op_alucont;
   assign alu_rd1     = op_a;
   assign alu_rd2     = op_b;

   // Both ports share the result registers; valid tells who owns them.
   assign rsp0_res  = res_q;
   assign rsp0_zero = zero_q;
   assign rsp1_res  = res_q;
   assign rsp1_zero = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. Provides the external
// ALU, runs a table of single-port operations with hand-computed results,
// hand-written arbitration/backpressure/reset sequences, and a randomized
// transaction run against a transaction-level model (pending requests per
// port, tie pointer, expected results from plain arithmetic).
// Build option: ALU_ARB_CNT_EN also checks the accept counters.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]   vld, rrdy, rdy, rspv, rzero;
   logic [3:0]   opc [2];
   logic [W-1:0] av [2];
   logic [W-1:0] bv [2];
   logic [W-1:0] rres [2];
   logic [3:0]   alu_alucont;
   logic [W-1:0] alu_rd1, alu_rd2, alu_res;
   logic         alu_zero;
`ifdef ALU_ARB_CNT_EN
   logic [15:0]  gc0, gc1;
`endif

   alu_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(vld[0]), .req0_ready(rdy[0]), .req0_alucont(opc[0]),
      .req0_a(av[0]), .req0_b(bv[0]),
      .req1_valid(vld[1]), .req1_ready(rdy[1]), .req1_alucont(opc[1]),
      .req1_a(av[1]), .req1_b(bv[1]),
      .rsp0_valid(rspv[0]), .rsp0_ready(rrdy[0]), .rsp0_res(rres[0]), .rsp0_zero(rzero[0]),
      .rsp1_valid(rspv[1]), .rsp1_ready(rrdy[1]), .rsp1_res(rres[1]), .rsp1_zero(rzero[1]),
      .alu_alucont(alu_alucont), .alu_rd1(alu_rd1), .alu_rd2(alu_rd2),
      .alu_res(alu_res), .alu_zero(alu_zero)
`ifdef ALU_ARB_CNT_EN
      , .grant0_cnt(gc0), .grant1_cnt(gc1)
`endif
   );

   function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      case (op)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_SLT: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         ALU_NOR: return ~(a | b);
         default: return a ^ b;  // unassigned codes: bench ALU does XOR
      endcase
   endfunction

   assign alu_res  = ref_alu(alu_alucont, alu_rd1, alu_rd2);
   assign alu_zero = (alu_res == '0);

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model state
   logic         rr_m;
   int           cnt_m [2];
   logic         pend [2];
   logic [3:0]   p_op [2];
   logic [W-1:0] p_a [2];
   logic [W-1:0] p_b [2];

   task automatic chk_counts(input string nm);
`ifdef ALU_ARB_CNT_EN
      chk({nm, " grant0_cnt"}, 64'(gc0), 64'(16'(cnt_m[0])));
      chk({nm, " grant1_cnt"}, 64'(gc1), 64'(16'(cnt_m[1])));
`else
      if (nm.len() < 0) $display("%s", nm);
`endif
   endtask

   // One full operation: accept, EXEC, RESP held for dly cycles, then fire.
   task automatic txn(input int dly, input bit use_exp, input logic [W-1:0] exp_res,
                      input logic exp_zero, input string nm);
      int g, o;
      logic [W-1:0] er;
      logic ez;
      for (int p = 0; p < 2; p++) begin
         vld[p] = pend[p]; opc[p] = p_op[p]; av[p] = p_a[p]; bv[p] = p_b[p];
      end
      #1;
      g = (pend[0] && pend[1]) ? (rr_m ? 1 : 0) : (pend[0] ? 0 : 1);
      o = 1 - g;
      er = use_exp ? exp_res : ref_alu(p_op[g], p_a[g], p_b[g]);
      ez = use_exp ? exp_zero : (er == '0);
      chk({nm, " ready_grantee"}, 64'(rdy[g]), 64'(1));
      chk({nm, " ready_other"}, 64'(rdy[o]), 64'(0));
      step();
      pend[g] = 1'b0; vld[g] = 1'b0; cnt_m[g]++;
      #1;
      chk({nm, " exec_alucont"}, 64'(alu_alucont), 64'(p_op[g]));
      chk({nm, " exec_rd1"}, 64'(alu_rd1), 64'(p_a[g]));
      chk({nm, " exec_rd2"}, 64'(alu_rd2), 64'(p_b[g]));
      chk({nm, " exec_rspv"}, 64'(rspv), 64'(0));
      chk({nm, " exec_ready"}, 64'(rdy), 64'(0));
      step();
      for (int k = 0; k <= dly; k++) begin
         if (k == dly) begin rrdy[o] = 1'b0; rrdy[g] = 1'b1; end
         else rrdy[o] = 1'($urandom_range(0, 1));
         #1;
         chk({nm, " resp_valid"}, 64'(rspv), (g == 1) ? 64'h2 : 64'h1);
         chk({nm, " resp_res"}, 64'(rres[g]), 64'(er));
         chk({nm, " resp_zero"}, 64'(rzero[g]), 64'(ez));
         chk({nm, " resp_ready"}, 64'(rdy), 64'(0));
         step();
      end
      rrdy = 2'b00;
      rr_m = (g == 0);
      #1;
      chk({nm, " idle_rspv"}, 64'(rspv), 64'(0));
      if (pend[o]) chk({nm, " next_accept"}, 64'(rdy[o]), 64'(1));
      chk_counts(nm);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " ready"}, 64'(rdy), 64'(0));
      chk({nm, " rspv"}, 64'(rspv), 64'(0));
      chk({nm, " alucont"}, 64'(alu_alucont), 64'(0));
      chk({nm, " rd1"}, 64'(alu_rd1), 64'(0));
      chk({nm, " rd2"}, 64'(alu_rd2), 64'(0));
      chk({nm, " res0"}, 64'(rres[0]), 64'(0));
      chk({nm, " res1"}, 64'(rres[1]), 64'(0));
      chk({nm, " zero"}, 64'(rzero), 64'(0));
   endtask

   task automatic do_reset();
      reset = 1'b1; vld = 2'b00; rrdy = 2'b00;
      step(); step();
      reset = 1'b0;
      rr_m = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0; cnt_m[0] = 0; cnt_m[1] = 0;
      step();
   endtask

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a, b, res;
      logic         zero;
      string        nm;
   } vec_t;
   vec_t tbl [12];

   initial begin
      tbl[0]  = '{ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, "add_5_7"};
      tbl[1]  = '{ALU_SUB, 32'd9, 32'd3, 32'd6, 1'b0, "sub_9_3"};
      tbl[2]  = '{ALU_SUB, 32'd5, 32'd5, 32'd0, 1'b1, "sub_eq"};
      tbl[3]  = '{ALU_AND, 32'hf0f0_00ff, 32'h0ff0_0f0f, 32'h00f0_000f, 1'b0, "and"};
      tbl[4]  = '{ALU_OR, 32'h1200_0034, 32'h0045_6000, 32'h1245_6034, 1'b0, "or"};
      tbl[5]  = '{ALU_SLT, 32'd3, 32'd9, 32'd1, 1'b0, "slt_lt"};
      tbl[6]  = '{ALU_SLT, 32'hffff_ffff, 32'd1, 32'd1, 1'b0, "slt_neg"};
      tbl[7]  = '{ALU_SLT, 32'd9, 32'd3, 32'd0, 1'b1, "slt_ge"};
      tbl[8]  = '{ALU_NOR, 32'd0, 32'd0, 32'hffff_ffff, 1'b0, "nor_0"};
      tbl[9]  = '{ALU_NOR, 32'hffff_0000, 32'h0000_ffff, 32'd0, 1'b1, "nor_all"};
      tbl[10] = '{4'b1111, 32'h1234_5678, 32'h0000_ffff, 32'h1234_a987, 1'b0, "opc_1111"};
      tbl[11] = '{ALU_ADD, 32'hffff_ffff, 32'd1, 32'd0, 1'b1, "add_wrap"};

      vld = 2'b00; rrdy = 2'b00;
      for (int p = 0; p < 2; p++) begin
         opc[p] = '0; av[p] = '0; bv[p] = '0; pend[p] = 1'b0;
         p_op[p] = '0; p_a[p] = '0; p_b[p] = '0; cnt_m[p] = 0;
      end
      rr_m = 1'b0;

      // Reset state, with both valids raised while reset is held
      step();
      vld = 2'b11;
      #1;
      chk_all_zero("reset");
      chk_counts("reset");
      vld = 2'b00;
      do_reset();

      // Table: single requester on port 0
      for (int i = 0; i < 12; i++) begin
         pend[0] = 1'b1; p_op[0] = tbl[i].op; p_a[0] = tbl[i].a; p_b[0] = tbl[i].b;
         txn(i % 3, 1'b1, tbl[i].res, tbl[i].zero, tbl[i].nm);
      end

      // Tie after reset: port 0 first, then port 1, then back to port 0;
      // port 1 then held off 5 cycles while port 0 keeps requesting.
      do_reset();
      pend[0] = 1'b1; p_op[0] = ALU_ADD; p_a[0] = 32'd1;  p_b[0] = 32'd2;
      pend[1] = 1'b1; p_op[1] = ALU_ADD; p_a[1] = 32'd10; p_b[1] = 32'd20;
      txn(0, 1'b1, 32'd3, 1'b0, "tie_first_p0");
      txn(0, 1'b1, 32'd30, 1'b0, "tie_then_p1");
      pend[0] = 1'b1; p_op[0] = ALU_OR;  p_a[0] = 32'h0f; p_b[0] = 32'hf0;
      pend[1] = 1'b1; p_op[1] = ALU_SUB; p_a[1] = 32'd100; p_b[1] = 32'd1;
      txn(0, 1'b1, 32'hff, 1'b0, "tie_back_p0");
      pend[0] = 1'b1; p_op[0] = ALU_AND; p_a[0] = 32'hff; p_b[0] = 32'h0f;
      txn(5, 1'b1, 32'd99, 1'b0, "hold_p1");
      txn(0, 1'b1, 32'h0f, 1'b0, "after_hold_p0");

      // Reset while SUB 9,3 is in EXEC: operation dropped
      do_reset();
      vld[0] = 1'b1; opc[0] = ALU_SUB; av[0] = 32'd9; bv[0] = 32'd3;
      #1;
      chk("rst_exec accept", 64'(rdy[0]), 64'(1));
      step();
      vld[0] = 1'b0;
      #1;
      chk("rst_exec in_exec", 64'(alu_alucont), 64'(ALU_SUB));
      reset = 1'b1;
      #1;
      chk_all_zero("rst_exec");
      step();
      reset = 1'b0;
      rr_m = 1'b0; cnt_m[0] = 0; cnt_m[1] = 0;
      for (int k = 0; k < 3; k++) begin
         chk("rst_exec no_rsp", 64'(rspv), 64'(0));
         step();
      end
      chk_counts("rst_exec");
      pend[0] = 1'b1; p_op[0] = ALU_ADD; p_a[0] = 32'd2; p_b[0] = 32'd3;
      txn(1, 1'b1, 32'd5, 1'b0, "rst_exec_next");

      // Randomized transactions against the model
      for (int it = 0; it < 300; it++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
               pend[p] = 1'b1;
               p_op[p] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                       : (($urandom_range(0, 1) == 1) ? ALU_ADD : ALU_SLT);
               p_a[p]  = $urandom;
               p_b[p]  = ($urandom_range(0, 3) == 0) ? p_a[p] : $urandom;
            end
         end
         if (!pend[0] && !pend[1]) begin
            pend[0] = 1'b1; p_op[0] = ALU_SUB; p_a[0] = $urandom; p_b[0] = p_a[0];
         end
         txn(int'($urandom_range(0, 3)), 1'b0, '0, 1'b0, "rand");
      end
      vld = 2'b00;

`ifdef ALU_ARB_CNT_EN
      // 65537 accepts on port 0: counter wraps to 1
      begin
         int acc;
         acc = 0;
         do_reset();
         vld[0] = 1'b1; rrdy[0] = 1'b1; opc[0] = ALU_ADD; av[0] = 32'd1; bv[0] = 32'd1;
         for (int c = 0; c < 65537 * 3 + 30 && acc < 65537; c++) begin
            if (rdy[0]) acc++;
            step();
         end
         vld[0] = 1'b0;
         chk("wrap accepts_seen", 64'(acc), 64'(65537));
         step(); step(); step();
         rrdy[0] = 1'b0;
         chk("wrap grant0_cnt", 64'(gc0), 64'(1));
         chk("wrap grant1_cnt", 64'(gc1), 64'(0));
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
